split_src: RTL and testbench
============================

// Module: split_src
// PURPOSE
//  Clocked token injector directly upstream of the dual-rail split stage.
//  Accepts binary data and a routing select over a valid/ready interface and buffers them in a FIFO.
//  Encodes each entry as one dual-rail token on in/sel and sequences the split's ack_o handshake.
//  Bridges the synchronous test/control domain into the clockless split/merge fabric.
// PARAMETERS
//  ENC          "TP"  rail protocol: "TP" two-phase transition, "FP" four-phase return-to-zero
//  WIDTH        1     data bits per token
//  DEPTH        4     FIFO entries; power of 2, >=2
//  SYNC_STAGES  2     flops on ack_i synchronizer; >=2
// PORTS
//  clk        in   1            sole clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  s_valid    in   1            upstream entry valid
//  s_ready    out  1            FIFO not full
//  s_data     in   WIDTH        binary data
//  s_sel      in   1            0 -> split out0, 1 -> split out1
//  ack_i      in   1            ack from split ack_o, asynchronous
//  out        out  WIDTH x 2    dual-rail data to split in; [b][1]=logic 1, [b][0]=logic 0
//  sel        out  2            dual-rail select to split sel; [1]=out1, [0]=out0
//  pending    out  clog2(DEPTH)+1  FIFO occupancy
//  proto_err  out  1            sticky: unexpected ack edge
// BEHAVIOUR
//  Reset (async assert, sync release): out=0, sel=0, FIFO empty, pending=0, s_ready=1,
//   ack_ref=0, proto_err=0, state=IDLE, synchronizer flops 0.
//  FIFO: push on s_valid&&s_ready; s_ready=!full, from registered count only.
//   A push while full is impossible by construction. Push+pop in one cycle leaves pending unchanged.
//   An entry pushed at edge E0 is launchable at E1 at the earliest (no fall-through).
//  ack_s = ack_i after SYNC_STAGES flops; all FSM decisions use ack_s only.
//  All rails driven straight from flops; per token exactly one rail per bit changes, plus one sel rail.
//  FSM for ENC="TP": IDLE, WAIT_ACK
//   IDLE & !empty: pop head. Toggle out[b][d_b] for each bit and sel[s] -> WAIT_ACK.
//   WAIT_ACK & ack_s!=ack_ref: ack_ref<=ack_s -> IDLE. Next launch no earlier than the following edge.
//  FSM for ENC="FP": IDLE, WAIT_ACK, RTZ, WAIT_NULL
//   IDLE & !empty: pop. out[b][d_b]=1, sel[s]=1, others 0 -> WAIT_ACK.
//   WAIT_ACK & ack_s=1: all rails 0 -> WAIT_NULL.
//   WAIT_NULL & ack_s=0 -> IDLE. RTZ is a one-cycle alias folded into that transition.
//  Latency: push into an empty IDLE block at E0 -> rails change after E1.
//   Throughput <= 1 token per (SYNC_STAGES+2) cycles (TP) or 2*(SYNC_STAGES+1)+1 cycles (FP).
//  proto_err set on an ack_s change while IDLE (TP) or ack_s=1 in IDLE/WAIT_NULL-entry mismatch (FP).
//   Once set, it clears only on rst. FSM continues regardless.
//  pending counts FIFO entries only; the in-flight token is excluded.
//  Reset mid-token: rails drop to 0 immediately and the FIFO is flushed.
//   The split must share rst; no partial token is resent.
//  Invalid ENC: compile-time $error.
// TESTING
//  1 TP, WIDTH=4: push d=0xA sel=1 -> out rails [3..0] toggle 1,0,1,0 and sel[1] toggles.
//    Hold ack -> no change. Toggle ack_i -> IDLE after SYNC_STAGES+1 edges.
//  2 FP, WIDTH=4: push 0x5 sel=0 -> out=1-hot {0,1,0,1}, sel=01.
//    ack_i=1 -> all rails 0. ack_i=0 -> IDLE. pending returns to 0.
//  3 DEPTH=4: push 6 back-to-back with ack_i stuck -> s_ready low after 5th push
//    (1 in flight + 4 buffered), pending=4. Released acks drain entries in push order.
//  4 Empty-FIFO push and launch in the same cycle as a pop: pending steady.
//    Order preserved across 16 random tokens vs scoreboard.
//  5 Toggle ack_i while IDLE (TP) -> proto_err=1 and stays 1 until rst.
//  6 Assert rst while in WAIT_ACK with 3 entries -> out=0, sel=0, pending=0, s_ready=1 immediately.

Source files
------------

// File: rtl/split_src.sv
// -----------------------------------------------------------------------------
// split_src
//
// Clocked token injector sitting directly upstream of the dual-rail split
// stage. Binary data and a routing select arrive over a valid/ready interface
// and are buffered in a small FIFO. Each entry is then encoded as one
// dual-rail token on out/sel, and the split's acknowledge is sequenced with
// either a two-phase (transition) or a four-phase (return-to-zero) protocol.
// This is the bridge from the synchronous control domain into the clockless
// split/merge fabric.
//
// Parameters
//   ENC          "TP" two-phase transition signalling, "FP" four-phase RTZ
//   WIDTH        data bits per token
//   DEPTH        FIFO entries (power of 2, >= 2)
//   SYNC_STAGES  flops on the ack_i synchronizer (>= 2)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset, released synchronously
//   s_valid    in   upstream entry valid
//   s_ready    out  FIFO not full
//   s_data     in   binary data word
//   s_sel      in   route select: 0 -> split out0, 1 -> split out1
//   ack_i      in   acknowledge from the split, asynchronous to clk
//   out        out  dual-rail data, out[b][1] = logic 1, out[b][0] = logic 0
//   sel        out  dual-rail select, sel[1] = out1, sel[0] = out0
//   pending    out  FIFO occupancy (the in-flight token is not counted)
//   proto_err  out  sticky flag for an unexpected acknowledge
// -----------------------------------------------------------------------------
module split_src #(
    parameter     ENC         = "TP",
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_sel,
    input  logic                       ack_i,
    output logic [WIDTH-1:0][1:0]      out,
    output logic [1:0]                 sel,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       proto_err
);

    localparam int             AW         = $clog2(DEPTH);
    localparam bit             IS_FP      = (ENC == "FP");
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (ENC != "TP" && ENC != "FP") begin : g_bad_enc
        $error("split_src: ENC must be \"TP\" or \"FP\"");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("split_src: DEPTH must be a power of 2 and at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("split_src: SYNC_STAGES must be at least 2");
    end

    // -------------------------------------------------------------------------
    // ack_i synchronizer; every FSM decision looks at ack_s only
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_s;

    // NOTE: clocked state is always written with <= so every flop samples the
    // pre-edge value of its neighbours; a blocking '=' here would collapse the
    // synchronizer chain into a single stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // FIFO: each entry holds {sel, data}
    // -------------------------------------------------------------------------
    logic [WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            push;
    logic            pop;
    logic            empty;
    logic [WIDTH:0]  head;

    // s_ready comes from the registered count only, so a push can never land
    // on a full FIFO even when a pop happens in the same cycle.
    assign s_ready = (count_q != FULL_COUNT);
    assign push    = s_valid && s_ready;
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are live, so flushing them is enough and the array maps
    // onto plain flops or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_sel, s_data};
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Dual-rail encoding of the FIFO head: one rail per bit, one select rail
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0][1:0] tok_rails;
    logic [1:0]            tok_sel;

    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            tok_rails[b] = head[b] ? 2'b10 : 2'b01;
        end
        tok_sel = head[WIDTH] ? 2'b10 : 2'b01;
    end

    // -------------------------------------------------------------------------
    // Handshake FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        RTZ       = 2'd2,
        WAIT_NULL = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0][1:0] out_q, out_d;
    logic [1:0]            sel_q, sel_d;
    logic                  ack_ref_q, ack_ref_d;
    logic                  err_q, err_d;

    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        sel_d     = sel_q;
        ack_ref_d = ack_ref_q;
        err_d     = err_q;
        pop       = 1'b0;

        if (IS_FP) begin
            // Four-phase: assert one rail per bit plus one select rail, wait
            // for ack high, drop everything to zero, wait for ack low.
            case (state_q)
                IDLE: begin
                    if (ack_s) begin
                        err_d = 1'b1;
                    end
                    if (!empty) begin
                        pop     = 1'b1;
                        out_d   = tok_rails;
                        sel_d   = tok_sel;
                        state_d = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s) begin
                        out_d   = '0;
                        sel_d   = '0;
                        state_d = WAIT_NULL;
                    end
                end
                WAIT_NULL: begin
                    // The return-to-zero cycle is folded into this transition
                    // rather than spent as a separate state.
                    if (!ack_s) begin
                        state_d = IDLE;
                    end
                end
                RTZ:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else begin
            // Two-phase: each token toggles one rail per bit plus one select
            // rail; any ack transition relative to ack_ref completes it.
            case (state_q)
                IDLE: begin
                    if (ack_s != ack_ref_q) begin
                        // Spurious ack edge: flag it and re-align the
                        // reference so the next token can still complete.
                        err_d     = 1'b1;
                        ack_ref_d = ack_s;
                    end
                    if (!empty) begin
                        pop     = 1'b1;
                        out_d   = out_q ^ tok_rails;
                        sel_d   = sel_q ^ tok_sel;
                        state_d = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_s != ack_ref_q) begin
                        ack_ref_d = ack_s;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            out_q     <= '0;
            sel_q     <= '0;
            ack_ref_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            sel_q     <= sel_d;
            ack_ref_q <= ack_ref_d;
            err_q     <= err_d;
        end
    end

    // Rails and flags are driven straight from flops: glitch-free into the
    // clockless fabric.
    assign out       = out_q;
    assign sel       = sel_q;
    assign pending   = count_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_split_src.sv
// -----------------------------------------------------------------------------
// tb_split_src
//
// Self-checking bench for split_src. One two-phase and one four-phase
// instance (WIDTH=4, DEPTH=4, SYNC_STAGES=2) share clk and rst. Expected
// rails come from a token scoreboard: a two-phase rail vector is the XOR of
// the one-hot encodings of every launched token, a four-phase rail vector is
// the one-hot encoding of the current token.
// -----------------------------------------------------------------------------
module tb_split_src;

    typedef struct packed {
        logic       s;
        logic [3:0] d;
    } tok_t;

    logic clk;
    logic rst;

    logic            tp_valid, tp_ready, tp_sel, tp_ack, tp_err;
    logic [3:0]      tp_data;
    logic [3:0][1:0] tp_out;
    logic [1:0]      tp_sel_o;
    logic [2:0]      tp_pending;
    logic [7:0]      tp_flat;

    logic            fp_valid, fp_ready, fp_sel, fp_ack, fp_err;
    logic [3:0]      fp_data;
    logic [3:0][1:0] fp_out;
    logic [1:0]      fp_sel_o;
    logic [2:0]      fp_pending;
    logic [7:0]      fp_flat;

    assign tp_flat = tp_out;
    assign fp_flat = fp_out;

    split_src #(.ENC("TP"), .WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)) u_tp (
        .clk(clk), .rst(rst),
        .s_valid(tp_valid), .s_ready(tp_ready), .s_data(tp_data), .s_sel(tp_sel),
        .ack_i(tp_ack), .out(tp_out), .sel(tp_sel_o),
        .pending(tp_pending), .proto_err(tp_err)
    );

    split_src #(.ENC("FP"), .WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)) u_fp (
        .clk(clk), .rst(rst),
        .s_valid(fp_valid), .s_ready(fp_ready), .s_data(fp_data), .s_sel(fp_sel),
        .ack_i(fp_ack), .out(fp_out), .sel(fp_sel_o),
        .pending(fp_pending), .proto_err(fp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    tok_t       tp_q[$];
    tok_t       fp_q[$];
    logic [7:0] tp_rails_m;
    logic [1:0] tp_sel_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-hot dual-rail image of a data word: bit b raises rail 2*b+d[b].
    function automatic logic [7:0] enc_rails(input logic [3:0] d);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) r[2*b + int'(d[b])] = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] enc_sel(input logic s);
        return s ? 2'b10 : 2'b01;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry and hold it until accepted (bounded wait).
    task automatic tp_push(input logic [3:0] d, input logic s);
        int n;
        n = 0;
        tp_valid = 1'b1; tp_data = d; tp_sel = s;
        @(negedge clk);
        while (!tp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tp_push_ready", tp_ready, 1'b1);
        tp_q.push_back(tok_t'({s, d}));
        step();
        tp_valid = 1'b0;
    endtask

    task automatic fp_push(input logic [3:0] d, input logic s);
        int n;
        n = 0;
        fp_valid = 1'b1; fp_data = d; fp_sel = s;
        @(negedge clk);
        while (!fp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("fp_push_ready", fp_ready, 1'b1);
        fp_q.push_back(tok_t'({s, d}));
        step();
        fp_valid = 1'b0;
    endtask

    // Wait for the next two-phase launch, check it against the scoreboard
    // head, then acknowledge it with one ack transition.
    task automatic tp_serve();
        tok_t t;
        int   n;
        n = 0;
        @(negedge clk);
        while ({tp_flat, tp_sel_o} == {tp_rails_m, tp_sel_m} && n < 60) begin
            @(negedge clk);
            n++;
        end
        t = tp_q.pop_front();
        tp_rails_m = tp_rails_m ^ enc_rails(t.d);
        tp_sel_m   = tp_sel_m ^ enc_sel(t.s);
        check("tp_serve_rails", tp_flat, tp_rails_m);
        check("tp_serve_sel", tp_sel_o, tp_sel_m);
        step();
        tp_ack = ~tp_ack;
    endtask

    // Four-phase: wait for the data wave, check it, raise ack, wait for the
    // null wave, check it, drop ack.
    task automatic fp_serve();
        tok_t t;
        int   n;
        n = 0;
        @(negedge clk);
        while (fp_flat == '0 && fp_sel_o == '0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        t = fp_q.pop_front();
        check("fp_serve_rails", fp_flat, enc_rails(t.d));
        check("fp_serve_sel", fp_sel_o, enc_sel(t.s));
        step();
        fp_ack = 1'b1;
        n = 0;
        @(negedge clk);
        while ((fp_flat != '0 || fp_sel_o != '0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("fp_null_rails", fp_flat, 8'h00);
        check("fp_null_sel", fp_sel_o, 2'b00);
        step();
        fp_ack = 1'b0;
    endtask

    initial begin
        logic [3:0] six_d;
        logic       six_s;
        int         pushed;
        int         k;

        rst = 1'b1;
        tp_valid = 1'b0; tp_data = '0; tp_sel = 1'b0; tp_ack = 1'b0;
        fp_valid = 1'b0; fp_data = '0; fp_sel = 1'b0; fp_ack = 1'b0;
        tp_rails_m = '0; tp_sel_m = '0;

        // ---------------- reset state ----------------
        #2;
        check("rst_tp_out", tp_flat, 8'h00);
        check("rst_tp_sel", tp_sel_o, 2'b00);
        check("rst_tp_pending", tp_pending, 3'd0);
        check("rst_tp_ready", tp_ready, 1'b1);
        check("rst_tp_err", tp_err, 1'b0);
        check("rst_fp_out", fp_flat, 8'h00);
        check("rst_fp_sel", fp_sel_o, 2'b00);
        check("rst_fp_pending", fp_pending, 3'd0);
        check("rst_fp_ready", fp_ready, 1'b1);
        check("rst_fp_err", fp_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // ---------------- two-phase: first token and latency ----------------
        tp_valid = 1'b1; tp_data = 4'hA; tp_sel = 1'b1;
        step();
        tp_valid = 1'b0;
        @(negedge clk);
        check("t1_no_fallthrough", tp_flat, 8'h00);
        @(posedge clk);
        @(negedge clk);
        tp_rails_m = enc_rails(4'hA);
        tp_sel_m   = enc_sel(1'b1);
        check("t1_rails", tp_flat, tp_rails_m);
        check("t1_sel", tp_sel_o, tp_sel_m);
        check("t1_pending", tp_pending, 3'd0);
        repeat (4) @(negedge clk);
        check("t1_hold_rails", tp_flat, tp_rails_m);
        check("t1_hold_sel", tp_sel_o, tp_sel_m);

        // second token waits behind the unacknowledged first one
        step();
        tp_valid = 1'b1; tp_data = 4'h3; tp_sel = 1'b0;
        step();
        tp_valid = 1'b0;
        @(negedge clk);
        check("t1_buffered", tp_pending, 3'd1);
        step();
        tp_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_ack_sync_rails", tp_flat, tp_rails_m);
        check("t1_ack_sync_pending", tp_pending, 3'd1);
        @(posedge clk);
        @(negedge clk);
        tp_rails_m = tp_rails_m ^ enc_rails(4'h3);
        tp_sel_m   = tp_sel_m ^ enc_sel(1'b0);
        check("t1_second_rails", tp_flat, tp_rails_m);
        check("t1_second_sel", tp_sel_o, tp_sel_m);
        check("t1_second_pending", tp_pending, 3'd0);
        step();
        tp_ack = 1'b0;
        repeat (5) step();

        // ---------------- four-phase: one token, full RTZ cycle ----------------
        fp_valid = 1'b1; fp_data = 4'h5; fp_sel = 1'b0;
        step();
        fp_valid = 1'b0;
        @(negedge clk);
        check("t2_no_fallthrough", fp_flat, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("t2_rails", fp_flat, enc_rails(4'h5));
        check("t2_sel", fp_sel_o, enc_sel(1'b0));
        check("t2_pending", fp_pending, 3'd0);
        repeat (3) @(negedge clk);
        check("t2_hold_rails", fp_flat, enc_rails(4'h5));
        step();
        fp_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t2_ack_sync_rails", fp_flat, enc_rails(4'h5));
        @(posedge clk);
        @(negedge clk);
        check("t2_null_rails", fp_flat, 8'h00);
        check("t2_null_sel", fp_sel_o, 2'b00);
        step();
        fp_ack = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("t2_pending_end", fp_pending, 3'd0);
        check("t2_err", fp_err, 1'b0);
        step();

        // ---------------- back-to-back fill with ack stuck ----------------
        tp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tp_data = 4'($urandom);
            tp_sel  = 1'($urandom);
            @(negedge clk);
            check("t3_ready", tp_ready, 1'b1);
            // second entry is pushed while the first launches: count steady
            check("t3_pending", tp_pending, (i <= 1) ? i : i - 1);
            tp_q.push_back(tok_t'({tp_sel, tp_data}));
            step();
        end
        six_d = 4'($urandom);
        six_s = 1'($urandom);
        tp_data = six_d; tp_sel = six_s;
        @(negedge clk);
        check("t3_full_ready", tp_ready, 1'b0);
        check("t3_full_pending", tp_pending, 3'd4);
        tp_valid = 1'b0;
        step();
        tp_serve();
        tp_push(six_d, six_s);
        for (int i = 0; i < 5; i++) tp_serve();
        repeat (5) step();
        @(negedge clk);
        check("t3_drained", tp_pending, 3'd0);
        step();

        // ---------------- random tokens, order vs scoreboard ----------------
        pushed = 0;
        while (pushed < 16) begin
            k = int'($urandom_range(3, 1));
            for (int j = 0; j < k && pushed < 16; j++) begin
                tp_push(4'($urandom), 1'($urandom));
                pushed++;
            end
            while (tp_q.size() > 0) tp_serve();
        end
        for (int i = 0; i < 8; i++) begin
            fp_push(4'($urandom), 1'($urandom));
            fp_serve();
        end
        repeat (5) step();
        @(negedge clk);
        check("t4_tp_pending", tp_pending, 3'd0);
        check("t4_tp_err", tp_err, 1'b0);
        check("t4_fp_pending", fp_pending, 3'd0);
        check("t4_fp_err", fp_err, 1'b0);
        step();

        // ---------------- reset while waiting for ack with 3 buffered ----------------
        for (int i = 0; i < 4; i++) tp_push(4'($urandom), 1'($urandom));
        @(negedge clk);
        check("t6_pre_pending", tp_pending, 3'd3);
        check("t6_pre_rails", tp_flat, tp_rails_m ^ enc_rails(tp_q[0].d));
        step();
        rst = 1'b1;
        #1;
        check("t6_rst_out", tp_flat, 8'h00);
        check("t6_rst_sel", tp_sel_o, 2'b00);
        check("t6_rst_pending", tp_pending, 3'd0);
        check("t6_rst_ready", tp_ready, 1'b1);
        tp_ack = 1'b0; fp_ack = 1'b0;
        tp_q.delete(); fp_q.delete();
        tp_rails_m = '0; tp_sel_m = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        tp_push(4'h6, 1'b1);
        tp_serve();
        repeat (5) step();
        @(negedge clk);
        check("t6_after_pending", tp_pending, 3'd0);
        step();

        // ---------------- spurious ack while idle ----------------
        tp_ack = ~tp_ack;
        fp_ack = 1'b1;
        repeat (5) step();
        @(negedge clk);
        check("t5_tp_err_set", tp_err, 1'b1);
        check("t5_fp_err_set", fp_err, 1'b1);
        fp_ack = 1'b0;
        repeat (15) step();
        @(negedge clk);
        check("t5_tp_err_sticky", tp_err, 1'b1);
        check("t5_fp_err_sticky", fp_err, 1'b1);
        step();
        rst = 1'b1;
        #1;
        check("t5_tp_err_cleared", tp_err, 1'b0);
        check("t5_fp_err_cleared", fp_err, 1'b0);
        tp_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
